scale_factor_sequencer: RTL

Sequences pitch-estimate requests through the scale_factor datapath.
- Accepts fundamental estimates from the pitch detector and drives scale_factor's fundamental/fundamental_valid/key_select inputs for one full LUT sweep.
- Captures the resulting factor and presents it as a registered, stable scale value to the resampler.
- Handles back-to-back requests, key changes, zero-pitch (unvoiced) frames and a missing-result timeout.

---
 rtl/scale_factor_sequencer.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/scale_factor_sequencer.sv
// -----------------------------------------------------------------------------
// scale_factor_sequencer
//
// Purpose:
//   Sits between the pitch detector and the scale_factor LUT datapath.
//   It takes fundamental estimates, drives scale_factor for one full LUT sweep,
//   captures the resulting factor and presents it to the resampler as a stable,
//   registered scale value.
//   Between sweeps fundamental_valid is forced low for GAP_CYCLES cycles. This
//   lets scale_factor clear its internal enable and sweep counter before the
//   next request starts.
//
//   Also handled:
//     - back-to-back requests, through a single pending slot (newest wins)
//     - key changes during a sweep (the sweep is aborted and restarted)
//     - unvoiced frames (fundamental 0): unity scale, no sweep
//     - a sweep that never produces factor_valid (timeout)
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   fund_in             new fundamental estimate (16Q21 unsigned)
//   fund_in_valid       one-cycle strobe qualifying fund_in
//   key_in              requested key
//   fundamental         to scale_factor.fundamental
//   fundamental_valid   to scale_factor.fundamental_valid
//   key_select          to scale_factor.key_select
//   factor              from scale_factor.factor (2Q21)
//   factor_valid        from scale_factor.factor_valid
//   scale_out           currently applied scale factor (2Q21)
//   scale_out_valid     one-cycle strobe on each scale_out update
//   busy                high while a sweep or inter-sweep gap is in progress
//   timeout_err         one-cycle strobe when a sweep times out
//
// All outputs are driven straight from registers.
// -----------------------------------------------------------------------------
module scale_factor_sequencer #(
    parameter int FUNDAMENTAL_WIDTH = 38,
    parameter int SCALE_WIDTH       = 24,
    parameter int FRAC_BITS         = 21,
    parameter int TIMEOUT           = 128,
    parameter int GAP_CYCLES        = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [FUNDAMENTAL_WIDTH-1:0] fund_in,
    input  logic                         fund_in_valid,
    input  logic [1:0]                   key_in,
    output logic [FUNDAMENTAL_WIDTH-1:0] fundamental,
    output logic                         fundamental_valid,
    output logic [1:0]                   key_select,
    input  logic [SCALE_WIDTH-1:0]       factor,
    input  logic                         factor_valid,
    output logic [SCALE_WIDTH-1:0]       scale_out,
    output logic                         scale_out_valid,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TCW-1:0]         TCNT_LAST = TCW'(TIMEOUT - 1);
    localparam logic [GCW-1:0]         GCNT_LAST = GCW'(GAP_CYCLES - 1);
    localparam logic [SCALE_WIDTH-1:0] UNITY     = SCALE_WIDTH'(64'd1 << FRAC_BITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                         r_state;
    logic [FUNDAMENTAL_WIDTH-1:0]   r_fund;
    logic                           r_fund_vld;
    logic [1:0]                     r_key;
    logic [SCALE_WIDTH-1:0]         r_scale;
    logic                           r_scale_vld;
    logic                           r_busy;
    logic                           r_tout;
    logic [TCW-1:0]                 r_tcnt;
    logic [GCW-1:0]                 r_gcnt;
    logic                           r_pend_vld;
    logic [FUNDAMENTAL_WIDTH-1:0]   r_pend_fund;
    logic [1:0]                     r_pend_key;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    state_t                         w_state_nxt;
    logic [FUNDAMENTAL_WIDTH-1:0]   w_fund_nxt;
    logic                           w_fund_vld_nxt;
    logic [1:0]                     w_key_nxt;
    logic [SCALE_WIDTH-1:0]         w_scale_nxt;
    logic                           w_scale_vld_nxt;
    logic                           w_busy_nxt;
    logic                           w_tout_nxt;
    logic [TCW-1:0]                 w_tcnt_nxt;
    logic [GCW-1:0]                 w_gcnt_nxt;
    logic                           w_pend_vld_nxt;
    logic [FUNDAMENTAL_WIDTH-1:0]   w_pend_fund_nxt;
    logic [1:0]                     w_pend_key_nxt;

    // A request strobed in the last GAP cycle is newer than whatever sits in
    // the pending slot. It is dequeued directly instead of being lost when the
    // slot is cleared.
    logic                           w_pend_vld_eff;
    logic [FUNDAMENTAL_WIDTH-1:0]   w_pend_fund_eff;
    logic [1:0]                     w_pend_key_eff;

    assign w_pend_vld_eff  = r_pend_vld | fund_in_valid;
    assign w_pend_fund_eff = fund_in_valid ? fund_in : r_pend_fund;
    assign w_pend_key_eff  = fund_in_valid ? key_in  : r_pend_key;

    // -------------------------------------------------------------------------
    // Next-state / output decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_fund_nxt      = r_fund;
        w_fund_vld_nxt  = r_fund_vld;
        w_key_nxt       = r_key;
        w_scale_nxt     = r_scale;
        w_scale_vld_nxt = 1'b0;
        w_tout_nxt      = 1'b0;
        w_tcnt_nxt      = r_tcnt;
        w_gcnt_nxt      = r_gcnt;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_fund_nxt = r_pend_fund;
        w_pend_key_nxt  = r_pend_key;

        // While busy, every new request lands in the single pending slot.
        if (fund_in_valid && (r_state != ST_IDLE)) begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_fund_nxt = fund_in;
            w_pend_key_nxt  = key_in;
        end

        case (r_state)
            ST_IDLE: begin
                if (fund_in_valid) begin
                    if (fund_in != '0) begin
                        w_state_nxt    = ST_RUN;
                        w_fund_nxt     = fund_in;
                        w_key_nxt      = key_in;
                        w_tcnt_nxt     = '0;
                        w_fund_vld_nxt = 1'b1;
                    end else begin
                        // Unvoiced frame: unity scale, no sweep.
                        w_scale_nxt     = UNITY;
                        w_scale_vld_nxt = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                w_tcnt_nxt = r_tcnt + TCW'(1);
                if (factor_valid) begin
                    // A result beats a simultaneous key change or timeout.
                    w_scale_nxt     = factor;
                    w_scale_vld_nxt = 1'b1;
                    w_state_nxt     = ST_GAP;
                    w_gcnt_nxt      = '0;
                    w_fund_vld_nxt  = 1'b0;
                end else if (key_in != r_key) begin
                    // Restart the same pitch under the new key after the gap.
                    // A fresh request strobed this cycle already holds the
                    // new key and is newer, so it keeps the slot.
                    if (!fund_in_valid) begin
                        w_pend_vld_nxt  = 1'b1;
                        w_pend_fund_nxt = r_fund;
                        w_pend_key_nxt  = key_in;
                    end
                    w_state_nxt    = ST_GAP;
                    w_gcnt_nxt     = '0;
                    w_fund_vld_nxt = 1'b0;
                end else if (r_tcnt == TCNT_LAST) begin
                    w_tout_nxt     = 1'b1;
                    w_state_nxt    = ST_GAP;
                    w_gcnt_nxt     = '0;
                    w_fund_vld_nxt = 1'b0;
                end
            end

            ST_GAP: begin
                w_gcnt_nxt = r_gcnt + GCW'(1);
                if (r_gcnt == GCNT_LAST) begin
                    w_pend_vld_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                    if (w_pend_vld_eff) begin
                        if (w_pend_fund_eff != '0) begin
                            w_state_nxt    = ST_RUN;
                            w_fund_nxt     = w_pend_fund_eff;
                            w_key_nxt      = w_pend_key_eff;
                            w_tcnt_nxt     = '0;
                            w_fund_vld_nxt = 1'b1;
                        end else begin
                            w_scale_nxt     = UNITY;
                            w_scale_vld_nxt = 1'b1;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt    = ST_IDLE;
                w_fund_vld_nxt = 1'b0;
            end
        endcase
    end

    // busy is registered from the next state, so it stays aligned with r_state.
    assign w_busy_nxt = (w_state_nxt != ST_IDLE);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_fund      <= '0;
            r_fund_vld  <= 1'b0;
            r_key       <= '0;
            r_scale     <= UNITY;
            r_scale_vld <= 1'b0;
            r_busy      <= 1'b0;
            r_tout      <= 1'b0;
            r_tcnt      <= '0;
            r_gcnt      <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_fund <= '0;
            r_pend_key  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fund      <= w_fund_nxt;
            r_fund_vld  <= w_fund_vld_nxt;
            r_key       <= w_key_nxt;
            r_scale     <= w_scale_nxt;
            r_scale_vld <= w_scale_vld_nxt;
            r_busy      <= w_busy_nxt;
            r_tout      <= w_tout_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_gcnt      <= w_gcnt_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_fund <= w_pend_fund_nxt;
            r_pend_key  <= w_pend_key_nxt;
        end
    end

    assign fundamental       = r_fund;
    assign fundamental_valid = r_fund_vld;
    assign key_select        = r_key;
    assign scale_out         = r_scale;
    assign scale_out_valid   = r_scale_vld;
    assign busy              = r_busy;
    assign timeout_err       = r_tout;

endmodule
